ct_biu_csr_bridge_sync: RTL and testbench

- Parametrised successor to the BIU other-IO sync path.
- Replaces the direct forwarding of the core CSR select with a real request/response bridge to the L2C/pad CSR port: edge-detected request, held payload, completion wait, timeout with error response.
- Also carries a configurable-width, configurable-depth synchroniser bank for external interrupt levels, with a combined wakeup output.
- Sits inside the BIU between the CP0/L2C CSR interface and the pad side.

---
 rtl/ct_biu_csr_pkg.sv | 27 ++
 rtl/ct_biu_sync_vec.sv | 34 +++
 rtl/ct_biu_csr_bridge_sync.sv | 135 +++++++++++++
 tb/tb_ct_biu_csr_bridge_sync.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/ct_biu_csr_pkg.sv
// Shared definitions for the BIU CSR bridge: FSM encoding, default widths
// and a constant-foldable clog2.
package ct_biu_csr_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_REQ  = 2'b01;
  localparam logic [1:0] ST_WAIT = 2'b10;
  localparam logic [1:0] ST_RESP = 2'b11;

  localparam int CSR_OP_W_DFLT        = 16;
  localparam int CSR_DATA_W_DFLT      = 64;
  localparam int CSR_RDATA_W_DFLT     = 128;
  localparam int CSR_TIMEOUT_DFLT     = 1024;
  localparam int CSR_INT_NUM_DFLT     = 6;
  localparam int CSR_SYNC_STAGES_DFLT = 2;

  // Returns 0 for values of 0 or 1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/ct_biu_sync_vec.sv
// Multi-bit level synchroniser bank; each bit gets an independent STAGES-deep
// flop chain. Intended for level signals only (no bus coherency implied).
module ct_biu_sync_vec
  import ct_biu_csr_pkg::*;
#(
  parameter int WIDTH  = CSR_INT_NUM_DFLT,
  parameter int STAGES = CSR_SYNC_STAGES_DFLT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] q_out
);

  logic [STAGES-1:0][WIDTH-1:0] stage_q;
  logic [STAGES-1:0][WIDTH-1:0] stage_d;

  assign stage_d[0] = d_in;

  genvar gi;
  generate
    for (gi = 1; gi < STAGES; gi++) begin : g_stage
      assign stage_d[gi] = stage_q[gi-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stage_q <= '0;
    else        stage_q <= stage_d;
  end

  assign q_out = stage_q[STAGES-1];

endmodule

// File: rtl/ct_biu_csr_bridge_sync.sv
// BIU CSR request/response bridge to the pad CSR port with completion timeout,
// plus the external interrupt synchroniser bank and wakeup.
module ct_biu_csr_bridge_sync
  import ct_biu_csr_pkg::*;
#(
  parameter int OP_W        = CSR_OP_W_DFLT,
  parameter int DATA_W      = CSR_DATA_W_DFLT,
  parameter int RDATA_W     = CSR_RDATA_W_DFLT,
  parameter int TIMEOUT     = CSR_TIMEOUT_DFLT,
  parameter int INT_NUM     = CSR_INT_NUM_DFLT,
  parameter int SYNC_STAGES = CSR_SYNC_STAGES_DFLT
) (
  input  logic                   coreclk,
  input  logic                   cpurst_b,
  input  logic                   biu_csr_sel,
  input  logic [OP_W-1:0]        biu_csr_op,
  input  logic [DATA_W-1:0]      biu_csr_wdata,
  output logic                   biu_csr_cmplt,
  output logic                   biu_csr_err,
  output logic [RDATA_W-1:0]     biu_csr_rdata,
  output logic                   biu_pad_csr_sel,
  output logic [OP_W+DATA_W-1:0] biu_pad_csr_wdata,
  input  logic                   pad_biu_csr_cmplt,
  input  logic [RDATA_W-1:0]     pad_biu_csr_rdata,
  input  logic [INT_NUM-1:0]     pad_biu_int,
  output logic [INT_NUM-1:0]     biu_cp0_int,
  output logic                   biu_xx_int_wakeup
);

  logic [1:0]             state_q, state_d;
  logic                   sel_ff_q;
  logic [OP_W+DATA_W-1:0] pad_wdata_q, pad_wdata_d;
  logic [RDATA_W-1:0]     rdata_q, rdata_d;
  logic                   err_q, err_d;
  logic                   req_pulse;
  logic                   timeout_hit;

  assign req_pulse = biu_csr_sel & ~sel_ff_q;

  always_comb begin
    state_d     = state_q;
    pad_wdata_d = pad_wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_pulse) begin
          state_d     = ST_REQ;
          pad_wdata_d = {biu_csr_op, biu_csr_wdata};
        end
      end
      ST_REQ: begin
        if (pad_biu_csr_cmplt) begin
          state_d = ST_RESP;
          rdata_d = pad_biu_csr_rdata;
          err_d   = 1'b0;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Completion takes priority over a timeout landing in the same cycle.
        if (pad_biu_csr_cmplt) begin
          state_d = ST_RESP;
          rdata_d = pad_biu_csr_rdata;
          err_d   = 1'b0;
        end else if (timeout_hit) begin
          state_d = ST_RESP;
          rdata_d = '0;
          err_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge coreclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q     <= ST_IDLE;
      sel_ff_q    <= 1'b0;
      pad_wdata_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_ff_q    <= biu_csr_sel;
      pad_wdata_q <= pad_wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  generate
    if (TIMEOUT != 0) begin : g_timeout
      localparam int CNT_W = clog2(TIMEOUT) + 1;
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
      logic [CNT_W-1:0] cnt_q, cnt_d;

      // Saturating so a stuck WAIT can never alias back to a small count.
      always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_RESP) cnt_d = '0;
        else if (state_q == ST_WAIT && cnt_q != '1) cnt_d = cnt_q + 1'b1;
      end

      always_ff @(posedge coreclk or negedge cpurst_b) begin
        if (!cpurst_b) cnt_q <= '0;
        else           cnt_q <= cnt_d;
      end

      assign timeout_hit = (state_q == ST_WAIT) && (cnt_q == CNT_LAST);
    end else begin : g_no_timeout
      assign timeout_hit = 1'b0;
    end
  endgenerate

  assign biu_pad_csr_sel   = (state_q == ST_REQ);
  assign biu_csr_cmplt     = (state_q == ST_RESP);
  assign biu_csr_err       = biu_csr_cmplt & err_q;
  assign biu_csr_rdata     = rdata_q;
  assign biu_pad_csr_wdata = pad_wdata_q;

  ct_biu_sync_vec #(
    .WIDTH  (INT_NUM),
    .STAGES (SYNC_STAGES)
  ) u_int_sync (
    .clk   (coreclk),
    .rst_n (cpurst_b),
    .d_in  (pad_biu_int),
    .q_out (biu_cp0_int)
  );

  assign biu_xx_int_wakeup = |biu_cp0_int;

endmodule

// File: tb/tb_ct_biu_csr_bridge_sync.sv
// Directed bench for ct_biu_csr_bridge_sync: table of CSR transactions plus
// hand sequences for held select, stray completion, mid-transaction reset and interrupt sync.
module tb_ct_biu_csr_bridge_sync;

  localparam int OP_W    = 16;
  localparam int DATA_W  = 64;
  localparam int RDATA_W = 128;
  localparam int INT_NUM = 6;

  logic                   coreclk;
  logic                   cpurst_b;
  logic                   biu_csr_sel;
  logic [OP_W-1:0]        biu_csr_op;
  logic [DATA_W-1:0]      biu_csr_wdata;
  logic                   biu_csr_cmplt;
  logic                   biu_csr_err;
  logic [RDATA_W-1:0]     biu_csr_rdata;
  logic                   biu_pad_csr_sel;
  logic [OP_W+DATA_W-1:0] biu_pad_csr_wdata;
  logic                   pad_biu_csr_cmplt;
  logic [RDATA_W-1:0]     pad_biu_csr_rdata;
  logic [INT_NUM-1:0]     pad_biu_int;
  logic [INT_NUM-1:0]     biu_cp0_int;
  logic                   biu_xx_int_wakeup;

  ct_biu_csr_bridge_sync #(
    .OP_W(OP_W), .DATA_W(DATA_W), .RDATA_W(RDATA_W),
    .TIMEOUT(8), .INT_NUM(INT_NUM), .SYNC_STAGES(3)
  ) dut (
    .coreclk           (coreclk),
    .cpurst_b          (cpurst_b),
    .biu_csr_sel       (biu_csr_sel),
    .biu_csr_op        (biu_csr_op),
    .biu_csr_wdata     (biu_csr_wdata),
    .biu_csr_cmplt     (biu_csr_cmplt),
    .biu_csr_err       (biu_csr_err),
    .biu_csr_rdata     (biu_csr_rdata),
    .biu_pad_csr_sel   (biu_pad_csr_sel),
    .biu_pad_csr_wdata (biu_pad_csr_wdata),
    .pad_biu_csr_cmplt (pad_biu_csr_cmplt),
    .pad_biu_csr_rdata (pad_biu_csr_rdata),
    .pad_biu_int       (pad_biu_int),
    .biu_cp0_int       (biu_cp0_int),
    .biu_xx_int_wakeup (biu_xx_int_wakeup)
  );

  initial coreclk = 1'b0;
  always #5 coreclk = ~coreclk;

  int n_cmp = 0;
  int n_bad = 0;

  // delay: cycle (0 = pad select cycle) in which pad cmplt is driven, -1 = never.
  // exp_resp: cycle in which core cmplt is expected.
  typedef struct {
    logic [15:0]  op;
    logic [63:0]  wdata;
    int           delay;
    logic [127:0] prdata;
    int           exp_resp;
    logic         exp_err;
    logic [127:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  int           pulses, sel_cyc, cmplt_n, cmplt_cyc;
  logic         err_at, stable;
  logic [127:0] rdata_at;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge coreclk);
    @(negedge coreclk);
  endtask

  // Observe 14 cycles after the request edge; cycle 0 is the expected pad select cycle.
  task automatic observe(input logic [79:0] exp_wdata, input int delay, input logic [127:0] prdata);
    pulses = 0; sel_cyc = -1; cmplt_n = 0; cmplt_cyc = -1;
    err_at = 1'b0; rdata_at = '0; stable = 1'b1;
    for (int c = 0; c < 14; c++) begin
      cycle();
      if (biu_pad_csr_sel) begin
        pulses++;
        if (sel_cyc < 0) sel_cyc = c;
      end
      if (biu_csr_cmplt) begin
        cmplt_n++;
        cmplt_cyc = c;
        err_at    = biu_csr_err;
        rdata_at  = biu_csr_rdata;
      end
      if (biu_pad_csr_wdata !== exp_wdata) stable = 1'b0;
      biu_csr_op        = ~biu_csr_op;
      biu_csr_wdata     = ~biu_csr_wdata;
      pad_biu_csr_cmplt = (c == delay);
      pad_biu_csr_rdata = (c == delay) ? prdata : {$urandom, $urandom, $urandom, $urandom};
    end
    pad_biu_csr_cmplt = 1'b0;
  endtask

  task automatic check_txn(input string tag, input int exp_resp, input logic exp_err,
                           input logic [127:0] exp_rdata);
    chk({tag, " pad_sel_count"}, 128'(pulses), 128'd1);
    chk({tag, " pad_sel_cycle"}, 128'(sel_cyc), 128'd0);
    chk({tag, " cmplt_count"}, 128'(cmplt_n), 128'd1);
    chk({tag, " cmplt_cycle"}, 128'(cmplt_cyc), 128'(exp_resp));
    chk({tag, " err"}, 128'(err_at), 128'(exp_err));
    chk({tag, " rdata"}, rdata_at, exp_rdata);
    chk({tag, " wdata_stable"}, 128'(stable), 128'd1);
    chk({tag, " rdata_hold"}, biu_csr_rdata, exp_rdata);
    $display("txn %s: pad_sel@%0d cmplt@%0d err=%b rdata=%h", tag, sel_cyc, cmplt_cyc,
             err_at, rdata_at);
  endtask

  // Drops sel for a cycle then raises it; sel is left high afterwards.
  task automatic run_txn(input vec_t v, input int idx);
    biu_csr_sel = 1'b0;
    cycle();
    biu_csr_op    = v.op;
    biu_csr_wdata = v.wdata;
    biu_csr_sel   = 1'b1;
    observe({v.op, v.wdata}, v.delay, v.prdata);
    check_txn($sformatf("vec%0d", idx), v.exp_resp, v.exp_err, v.exp_rdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [5:0] int_pat [2];
    int p_cnt, c_cnt;

    vecs[0] = '{16'h0012, 64'hDEAD_BEEF, 5, 128'h1234, 6, 1'b0, 128'h1234};
    vecs[1] = '{16'hABCD, 64'h0123_4567_89AB_CDEF, 0, {4{32'hFFFF_0000}}, 1, 1'b0, {4{32'hFFFF_0000}}};
    vecs[2] = '{16'h0001, 64'h1, 1, 128'hA5A5, 2, 1'b0, 128'hA5A5};
    vecs[3] = '{16'h00FE, 64'h77, -1, 128'h0, 9, 1'b1, 128'h0};
    vecs[4] = '{16'h0100, 64'h55, 8, 128'h5555_6666, 9, 1'b0, 128'h5555_6666};
    vecs[5] = '{16'h0200, 64'h99, 7, 128'hC0FFEE, 8, 1'b0, 128'hC0FFEE};
    int_pat[0] = 6'b000100;
    int_pat[1] = 6'b100001;

    cpurst_b = 1'b0; biu_csr_sel = 1'b0; biu_csr_op = '0; biu_csr_wdata = '0;
    pad_biu_csr_cmplt = 1'b0; pad_biu_csr_rdata = '0; pad_biu_int = '0;
    cycle(); cycle();
    pad_biu_int = 6'b111111;
    cycle();
    chk("rst pad_sel", 128'(biu_pad_csr_sel), 128'd0);
    chk("rst pad_wdata", 128'(biu_pad_csr_wdata), 128'd0);
    chk("rst cmplt", 128'(biu_csr_cmplt), 128'd0);
    chk("rst err", 128'(biu_csr_err), 128'd0);
    chk("rst rdata", biu_csr_rdata, 128'd0);
    chk("rst cp0_int", 128'(biu_cp0_int), 128'd0);
    chk("rst wakeup", 128'(biu_xx_int_wakeup), 128'd0);
    pad_biu_int = '0;
    cpurst_b = 1'b1;
    cycle(); cycle(); cycle();

    for (int i = 0; i < 6; i++) run_txn(vecs[i], i);

    // sel still high from the last transaction; stray completion in IDLE.
    pad_biu_csr_cmplt = 1'b1;
    pad_biu_csr_rdata = 128'hBAD0_BAD0;
    cycle();
    pad_biu_csr_cmplt = 1'b0;
    p_cnt = 0; c_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      cycle();
      if (biu_pad_csr_sel) p_cnt++;
      if (biu_csr_cmplt) c_cnt++;
    end
    chk("held pad_sel_count", 128'(p_cnt), 128'd0);
    chk("held cmplt_count", 128'(c_cnt), 128'd0);
    chk("held rdata_hold", biu_csr_rdata, vecs[5].exp_rdata);
    $display("txn held/stray: pad_sel=%0d cmplt=%0d", p_cnt, c_cnt);
    run_txn('{16'h0300, 64'h1111, 2, 128'hBEEF, 3, 1'b0, 128'hBEEF}, 6);

    // Reset while in WAIT, completion during reset, sel high at release.
    biu_csr_sel = 1'b0;
    cycle();
    biu_csr_op = 16'h0BAD; biu_csr_wdata = 64'hCAFE; biu_csr_sel = 1'b1;
    cycle(); cycle(); cycle();
    chk("pre-rst pad_wdata", 128'(biu_pad_csr_wdata), 128'({16'h0BAD, 64'hCAFE}));
    cpurst_b = 1'b0;
    #1;
    chk("mid-rst pad_sel", 128'(biu_pad_csr_sel), 128'd0);
    chk("mid-rst cmplt", 128'(biu_csr_cmplt), 128'd0);
    chk("mid-rst pad_wdata", 128'(biu_pad_csr_wdata), 128'd0);
    chk("mid-rst rdata", biu_csr_rdata, 128'd0);
    pad_biu_csr_cmplt = 1'b1;
    pad_biu_csr_rdata = 128'h7777;
    cycle();
    chk("in-rst cmplt", 128'(biu_csr_cmplt), 128'd0);
    pad_biu_csr_cmplt = 1'b0;
    cpurst_b = 1'b1;
    observe({16'h0BAD, 64'hCAFE}, -1, 128'h0);
    check_txn("post-rst", 9, 1'b1, 128'h0);
    biu_csr_sel = 1'b0;

    for (int p = 0; p < 2; p++) begin
      pad_biu_int = int_pat[p];
      for (int k = 1; k <= 4; k++) begin
        cycle();
        chk($sformatf("int_set%0d cp0_int e%0d", p, k), 128'(biu_cp0_int),
            128'((k >= 3) ? int_pat[p] : 6'b0));
        chk($sformatf("int_set%0d wakeup e%0d", p, k), 128'(biu_xx_int_wakeup),
            128'(k >= 3));
      end
      pad_biu_int = '0;
      for (int k = 1; k <= 4; k++) begin
        cycle();
        chk($sformatf("int_clr%0d cp0_int e%0d", p, k), 128'(biu_cp0_int),
            128'((k >= 3) ? 6'b0 : int_pat[p]));
        chk($sformatf("int_clr%0d wakeup e%0d", p, k), 128'(biu_xx_int_wakeup),
            128'(k < 3));
      end
      $display("txn int pattern %b: sync set/clear sequence done", int_pat[p]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
